// File: rtl/low_latency_10g_1ch_pll_reset_ctrl.sv
// Reset/lock sequencer for the 1-channel 10G fabric PLL (100 MHz refclk in, 625 MHz out).
// Holds the PLL in reset, qualifies lock with a stability window, retries on timeout,
// and latches a sticky failure after too many timeouts.
//
// Ports:
//   refclk         in   free-running reference clock, sole clock
//   rst            in   synchronous active-high reset
//   pll_locked     in   PLL lock indication, asynchronous to refclk
//   force_relock   in   single-cycle request to re-sequence the PLL
//   pll_rst        out  reset to the PLL
//   pll_ready      out  qualified lock, high only in READY
//   downstream_rst out  registered ~pll_ready for 625 MHz domain users
//   retry_count    out  timeouts since rst, saturating at 15
//   lock_fail      out  sticky failure, high in FAIL

module low_latency_10g_1ch_pll_reset_ctrl #(
    parameter int RST_HOLD_CYCLES     = 100,
    parameter int LOCK_STABLE_CYCLES  = 1000,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int MAX_RETRIES         = 7
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       pll_ready,
    output logic       downstream_rst,
    output logic [3:0] retry_count,
    output logic       lock_fail
);

    localparam int MAX_A   = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ?
                             RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
    localparam int CNT_MAX = (MAX_A > LOCK_TIMEOUT_CYCLES) ?
                             MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int CW      = ($clog2(CNT_MAX) > 0) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_READY,
        S_FAIL
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [3:0]    retry_nxt;
    logic          lock_m;
    logic          lock_s;
    logic          counting;

    // Two-flop synchronizer; only lock_s feeds decisions.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_locked;
            lock_s <= lock_m;
        end
    end

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_count;
        unique case (state)
            S_RESET: begin
                // force_relock is deliberately ignored here
                if (cnt == HOLD_LAST)
                    state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (force_relock) begin
                    state_nxt = S_RESET;
                end else if (lock_s) begin
                    state_nxt = S_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry_count != 4'hf)
                        retry_nxt = retry_count + 4'd1;
                    state_nxt = (retry_nxt >= RETRY_LIMIT) ? S_FAIL : S_RESET;
                end
            end
            S_STABLE: begin
                if (force_relock)
                    state_nxt = S_RESET;
                else if (!lock_s)
                    state_nxt = S_WAIT_LOCK;
                else if (cnt == STABLE_LAST)
                    state_nxt = S_READY;
            end
            S_READY: begin
                if (force_relock || !lock_s)
                    state_nxt = S_RESET;
            end
            S_FAIL: begin
                if (force_relock) begin
                    state_nxt = S_RESET;
                    retry_nxt = 4'd0;
                end
            end
            default: state_nxt = S_RESET;
        endcase
    end

    // Only the timed states advance the counter; READY and FAIL park it at 0.
    assign counting = (state == S_RESET) || (state == S_WAIT_LOCK) ||
                      (state == S_STABLE);

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state          <= S_RESET;
            cnt            <= '0;
            retry_count    <= 4'd0;
            pll_rst        <= 1'b1;
            pll_ready      <= 1'b0;
            downstream_rst <= 1'b1;
            lock_fail      <= 1'b0;
        end else begin
            state          <= state_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else if (counting)
                cnt <= cnt + CW'(1);
            retry_count    <= retry_nxt;
            pll_rst        <= (state_nxt == S_RESET) || (state_nxt == S_FAIL);
            pll_ready      <= (state_nxt == S_READY);
            downstream_rst <= ~pll_ready;
            lock_fail      <= (state_nxt == S_FAIL);
        end
    end

endmodule

// File: tb/tb_low_latency_10g_1ch_pll_reset_ctrl.sv
// Bench for low_latency_10g_1ch_pll_reset_ctrl: hand-derived vector table,
// a directed corner sequence, and random stimulus against a behavioural model.

module tb_low_latency_10g_1ch_pll_reset_ctrl;

    localparam int HOLD = 4;
    localparam int STBL = 8;
    localparam int TOUT = 32;
    localparam int MAXR = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       force_relock = 1'b0;
    logic       pll_rst;
    logic       pll_ready;
    logic       downstream_rst;
    logic [3:0] retry_count;
    logic       lock_fail;
    logic [7:0] outs;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    low_latency_10g_1ch_pll_reset_ctrl #(
        .RST_HOLD_CYCLES    (HOLD),
        .LOCK_STABLE_CYCLES (STBL),
        .LOCK_TIMEOUT_CYCLES(TOUT),
        .MAX_RETRIES        (MAXR)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .force_relock  (force_relock),
        .pll_rst       (pll_rst),
        .pll_ready     (pll_ready),
        .downstream_rst(downstream_rst),
        .retry_count   (retry_count),
        .lock_fail     (lock_fail)
    );

    always #5 refclk = ~refclk;

    assign outs = {pll_rst, pll_ready, downstream_rst, retry_count, lock_fail};

    // Behavioural model: phase 0 hold, 1 waiting, 2 qualifying, 3 ready, 4 failed.
    int   ph = 0;
    int   age = 0;
    int   retries = 0;
    logic mm = 1'b0;
    logic ms = 1'b0;
    logic e_rst = 1'b1;
    logic e_rdy = 1'b0;
    logic e_ds = 1'b1;
    logic e_fail = 1'b0;

    task automatic model_edge(input logic r, input logic l, input logic f);
        int nx;
        logic ls;
        ls = ms;
        if (r) begin
            ph = 0; age = 0; retries = 0; mm = 1'b0; ms = 1'b0;
            e_rst = 1'b1; e_rdy = 1'b0; e_ds = 1'b1; e_fail = 1'b0;
        end else begin
            nx = ph;
            if (ph == 0) begin
                if (age == HOLD - 1) nx = 1;
            end else if (ph == 1) begin
                if (f) nx = 0;
                else if (ls) nx = 2;
                else if (age == TOUT - 1) begin
                    retries = (retries < 15) ? retries + 1 : 15;
                    nx = (retries >= MAXR) ? 4 : 0;
                end
            end else if (ph == 2) begin
                if (f) nx = 0;
                else if (!ls) nx = 1;
                else if (age == STBL - 1) nx = 3;
            end else if (ph == 3) begin
                if (f || !ls) nx = 0;
            end else begin
                if (f) begin nx = 0; retries = 0; end
            end
            age = (nx == ph) ? age + 1 : 0;
            ph = nx;
            e_ds = !e_rdy;
            e_rdy = (ph == 3);
            e_rst = (ph == 0) || (ph == 4);
            e_fail = (ph == 4);
            ms = mm;
            mm = l;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d: got rst/rdy/ds/cnt/fail=%b_%b_%b_%h_%b want %b_%b_%b_%h_%b",
                     name, cyc, act[7], act[6], act[5], act[4:1], act[0],
                     exp[7], exp[6], exp[5], exp[4:1], exp[0]);
        end
    endtask

    task automatic step(input logic r, input logic l, input logic f);
        rst = r;
        pll_locked = l;
        force_relock = f;
        @(posedge refclk);
        model_edge(r, l, f);
        @(negedge refclk);
        cyc++;
        chk("model", outs, {e_rst, e_rdy, e_ds, 4'(retries), e_fail});
    endtask

    typedef struct {
        logic       r;
        logic       l;
        logic       f;
        int         n;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic l, input logic f,
                                input int n, input logic pr, input logic rd,
                                input logic ds, input logic [3:0] rc,
                                input logic fl);
        vec_t v;
        v.r = r; v.l = l; v.f = f; v.n = n;
        v.exp = {pr, rd, ds, rc, fl};
        return v;
    endfunction

    initial begin
        int k;
        logic lv;
        int hold;

        // cold start, lock 10 cycles after pll_rst falls
        tbl.push_back(mk(1, 0, 0, 3,    1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3,    1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,    0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 9,    0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 10,   0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1,    0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1,    0, 1, 0, 0, 0));
        // lock lost in READY
        tbl.push_back(mk(0, 0, 0, 2,    0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,    1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,    1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 2,    1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,    0, 0, 1, 0, 0));
        // relock with a glitch at window count 5
        tbl.push_back(mk(0, 1, 0, 6,    0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,    0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 10,   0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1,    0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1,    0, 1, 0, 0, 0));
        // rst mid-READY, then mid-STABLE
        tbl.push_back(mk(1, 1, 0, 1,    1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 7,    0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1,    1, 0, 1, 0, 0));
        // force during hold does not stretch it
        tbl.push_back(mk(0, 0, 0, 2,    1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1,    1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,    0, 0, 1, 0, 0));
        // two timeouts into FAIL, then hold
        tbl.push_back(mk(0, 0, 0, 31,   0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,    1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 4,    0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 31,   0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1,    1, 0, 1, 2, 1));
        tbl.push_back(mk(0, 0, 0, 1000, 1, 0, 1, 2, 1));
        // force out of FAIL with a healthy PLL
        tbl.push_back(mk(0, 1, 1, 1,    1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 11,   0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1,    0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1,    0, 1, 1, 0, 0));
        // force in READY
        tbl.push_back(mk(0, 1, 1, 1,    1, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            for (int j = 0; j < tbl[i].n; j++)
                step(tbl[i].r, tbl[i].l, tbl[i].f);
            chk($sformatf("row%0d", i), outs, tbl[i].exp);
        end

        // force and synced lock loss in the same READY cycle: one hold only
        k = 0;
        while (!pll_ready && k < 100) begin
            step(0, 1, 0);
            k++;
        end
        chk("reach_ready", {7'd0, pll_ready}, 8'd1);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        chk("dual_event", {6'd0, pll_rst, pll_ready}, 8'b10);
        for (int j = 0; j < 3; j++)
            step(0, 0, 0);
        chk("dual_hold", {7'd0, pll_rst}, 8'd1);
        step(0, 0, 0);
        chk("dual_release", {7'd0, pll_rst}, 8'd0);

        // random PLL behaviour against the model
        lv = 1'b0;
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                lv = ($urandom_range(0, 3) != 0);
                hold = $urandom_range(1, 60);
            end
            hold--;
            step($urandom_range(0, 299) == 0, lv, $urandom_range(0, 63) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc %0d: got no finish want finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
